// File: rtl/reg_access_pkg.sv
// rtl/reg_access_pkg.sv - shared types and constants for the register access controller
package reg_access_pkg;
  localparam int NREGS = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_SW_WR,
    ST_RESP
  } state_e;
endpackage

// File: rtl/reg_sel_decoder.sv
// rtl/reg_sel_decoder.sv - register index to one-hot strobe decoder with enable
module reg_sel_decoder #(
  parameter int AW    = 4,
  parameter int NREGS = 16
) (
  input  logic             en,
  input  logic [AW-1:0]    idx,
  output logic [NREGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - turns read/write/swap requests into register bank load/drive strobes
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int NREGS = reg_access_pkg::NREGS,
  parameter int DW    = reg_access_pkg::DW,
  parameter int AW    = reg_access_pkg::AW
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_reg,
  input  logic             req_base,
  input  logic [DW-1:0]    req_wdata,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             ba_out,
  output logic [DW-1:0]    d_out,
  input  logic [DW-1:0]    bus_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             err
);
  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [AW-1:0]   reg_q;
  logic            base_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   d_out_q, d_out_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            err_q, err_d;
  logic            accept;
  logic            rin_en, rout_en;

  // Gating with clear_n keeps ready low for the whole reset window.
  assign req_ready = clear_n && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      reg_q      <= '0;
      base_q     <= 1'b0;
      wdata_q    <= '0;
      d_out_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_out_q    <= d_out_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      if (accept) begin
        op_q    <= req_op;
        reg_q   <= req_reg;
        base_q  <= req_base;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    d_out_d    = d_out_q;
    rsp_data_d = rsp_data_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_WRITE: begin
              state_d = ST_WR;
              d_out_d = req_wdata;
            end
            OP_READ, OP_SWAP: state_d = ST_RD;
            default:          err_d   = 1'b1;
          endcase
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD: begin
        rsp_data_d = bus_in;
        if (op_q == OP_SWAP) begin
          state_d = ST_SW_WR;
          d_out_d = wdata_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_SW_WR: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset kills them at once.
  assign rin_en  = (state_q == ST_WR) || (state_q == ST_SW_WR);
  assign rout_en = (state_q == ST_RD);

  reg_sel_decoder #(.AW(AW), .NREGS(NREGS)) u_rin_dec (
    .en     (rin_en),
    .idx    (reg_q),
    .onehot (rin)
  );

  reg_sel_decoder #(.AW(AW), .NREGS(NREGS)) u_rout_dec (
    .en     (rout_en),
    .idx    (reg_q),
    .onehot (rout)
  );

  assign ba_out    = rout_en && base_q && (reg_q == '0);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign d_out     = d_out_q;
  assign err       = err_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - self-checking bench for reg_access_ctrl with a behavioural register bank
module tb_reg_access_ctrl;
  logic        clk;
  logic        clear_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_reg;
  logic        req_base;
  logic [31:0] req_wdata;
  logic [15:0] rin;
  logic [15:0] rout;
  logic        ba_out;
  logic [31:0] d_out;
  logic [31:0] bus_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        err;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] bank [16];
  logic [31:0] model [16];

  reg_access_ctrl dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_reg   (req_reg),
    .req_base  (req_base),
    .req_wdata (req_wdata),
    .rin       (rin),
    .rout      (rout),
    .ba_out    (ba_out),
    .d_out     (d_out),
    .bus_in    (bus_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++)
      if (rin[i]) bank[i] <= d_out;
  end

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < 16; i++)
      if (rout[i]) bus_in = bus_in | ((i == 0 && ba_out) ? 32'h0 : bank[i]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] r, input logic base,
                        input logic [31:0] wd, input int hold);
    logic [15:0] mask;
    logic [31:0] exp_data, got;
    int n_rin, n_rout, n_err, rsp_cyc, done_cyc, cyc;
    int exp_rin, exp_rout, exp_rsp, exp_done;
    logic ba_seen, exp_ba, onehot_bad, overlap_bad, dout_bad, stable_bad;
    mask = 16'h0001 << r;
    exp_data = (base && r == 4'd0) ? 32'h0 : model[r];
    exp_rin  = (op == 2'b01 || op == 2'b10) ? 1 : 0;
    exp_rout = (op == 2'b00 || op == 2'b10) ? 1 : 0;
    exp_rsp  = (op == 2'b00) ? 2 : (op == 2'b10) ? 3 : 0;
    exp_done = (op == 2'b01) ? 2 : (op == 2'b11) ? 1 : (op == 2'b00) ? 3 + hold : 4 + hold;
    exp_ba   = (op == 2'b00 || op == 2'b10) && base && (r == 4'd0);
    n_rin = 0; n_rout = 0; n_err = 0; rsp_cyc = 0; done_cyc = 0; cyc = 1;
    ba_seen = 1'b0; onehot_bad = 1'b0; overlap_bad = 1'b0; dout_bad = 1'b0; stable_bad = 1'b0;
    got = '0;

    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_reg = r; req_base = base; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_reg = 4'($urandom);
    req_base = 1'($urandom); req_wdata = $urandom;

    while (done_cyc == 0 && cyc < 40) begin
      if (rin != '0) begin
        n_rin++;
        if (rin !== mask) onehot_bad = 1'b1;
        if (d_out !== wd) dout_bad = 1'b1;
      end
      if (rout != '0) begin
        n_rout++;
        if (rout !== mask) onehot_bad = 1'b1;
      end
      if (rin != '0 && rout != '0) overlap_bad = 1'b1;
      if (ba_out === 1'b1) ba_seen = 1'b1;
      if (err === 1'b1) n_err++;
      if (rsp_valid === 1'b1 && rsp_cyc == 0) begin
        rsp_cyc = cyc;
        got = rsp_data;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1; cyc++;
          if (rsp_valid !== 1'b1 || rsp_data !== got || req_ready !== 1'b0 ||
              rin != '0 || rout != '0) stable_bad = 1'b1;
        end
        rsp_ready = 1'b1;
      end
      if (req_ready === 1'b1) done_cyc = cyc;
      else begin
        @(posedge clk); #1; cyc++;
      end
    end

    chk("op_completed",   32'(done_cyc != 0), 32'd1);
    chk("ready_latency",  32'(done_cyc), 32'(exp_done));
    chk("rin_cycles",     32'(n_rin), 32'(exp_rin));
    chk("rout_cycles",    32'(n_rout), 32'(exp_rout));
    chk("strobe_onehot",  {31'b0, onehot_bad}, 32'd0);
    chk("strobe_overlap", {31'b0, overlap_bad}, 32'd0);
    chk("d_out_value",    {31'b0, dout_bad}, 32'd0);
    chk("ba_out",         {31'b0, ba_seen}, {31'b0, exp_ba});
    chk("err_pulses",     32'(n_err), (op == 2'b11) ? 32'd1 : 32'd0);
    chk("rsp_latency",    32'(rsp_cyc), 32'(exp_rsp));
    chk("rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
    if (exp_rsp != 0) begin
      chk("rsp_data",   got, exp_data);
      chk("rsp_stable", {31'b0, stable_bad}, 32'd0);
    end
    if (op == 2'b11) begin
      @(posedge clk); #1;
      chk("err_single_cycle", {31'b0, err}, 32'd0);
    end
    if (op == 2'b01 || op == 2'b10) model[r] = wd;
  endtask

  initial begin
    logic rsp_seen;
    clear_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_reg = 4'd0;
    req_base = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rin",       {16'b0, rin}, 32'd0);
    chk("rst_rout",      {16'b0, rout}, 32'd0);
    chk("rst_ba_out",    {31'b0, ba_out}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_err",       {31'b0, err}, 32'd0);
    chk("rst_d_out",     d_out, 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    #1;
    chk("ready_after_release", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run_op(2'b01, 4'(i), 1'b0, $urandom, 0);

    run_op(2'b01, 4'd3, 1'b0, 32'hDEADBEEF, 0);
    run_op(2'b00, 4'd3, 1'b0, 32'h0, 0);
    run_op(2'b01, 4'd0, 1'b0, 32'h12345678, 0);
    run_op(2'b00, 4'd0, 1'b1, 32'h0, 0);
    run_op(2'b00, 4'd0, 1'b0, 32'h0, 0);
    run_op(2'b00, 4'd7, 1'b1, 32'h0, 0);
    run_op(2'b01, 4'd15, 1'b0, 32'h0000000A, 0);
    run_op(2'b10, 4'd15, 1'b0, 32'h0000000B, 0);
    run_op(2'b00, 4'd15, 1'b0, 32'h0, 0);
    run_op(2'b00, 4'd9, 1'b0, 32'h0, 5);
    run_op(2'b11, 4'd4, 1'b0, 32'h55AA55AA, 0);

    req_valid = 1'b1; req_op = 2'b00; req_reg = 4'd5; req_base = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midop_rout_active", {16'b0, rout}, 32'h0020);
    #2 clear_n = 1'b0;
    #1;
    chk("midop_rout_dropped", {16'b0, rout}, 32'd0);
    chk("midop_rin_low",      {16'b0, rin}, 32'd0);
    chk("midop_ready_low",    {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    #1;
    chk("midop_ready_release", {31'b0, req_ready}, 32'd1);
    rsp_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) rsp_seen = 1'b1;
    end
    chk("midop_no_response", {31'b0, rsp_seen}, 32'd0);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom, int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
- Initiator side of the register-file load/drive interface: turns valid/ready read, write and swap requests into one-hot load strobes (Rin), one-hot drive strobes (Rout) and the base-address strobe (BAout) for the general-purpose registers.
- Samples the shared register output bus and returns read data on a valid/ready response channel.
- Sits between the control sequencer/debug port and the 16 x 32-bit register bank (R0 through R15).

Parameters:
- NREGS, 16, number of addressable registers; sets the strobe width.
- DW, 32, data and bus width.
- AW, 4, register index width; must equal clog2(NREGS).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 READ, 01 WRITE, 10 SWAP, 11 reserved.
- req_reg  in  AW  target register index.
- req_base  in  1  base-address read; meaningful for index 0 only.
- req_wdata  in  DW  write data for WRITE and SWAP.
- rin  out  NREGS  one-hot load strobe to register bank.
- rout  out  NREGS  one-hot drive strobe to register bank.
- ba_out  out  1  base-address strobe; forces R0 to drive zero.
- d_out  out  DW  data to the register D inputs.
- bus_in  in  DW  OR-combined register Q bus; combinational from register contents.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DW  captured register value.
- err  out  1  one-cycle pulse when a reserved op is accepted.

Behaviour:
- Reset (clear_n low, async) forces:
  - state IDLE;
  - rin, rout, ba_out, rsp_valid and err low;
  - d_out and rsp_data zero;
  - req_ready low while clear_n is low, high in the first cycle after release.
- Strobes drop immediately on reset assertion, including mid-operation. An interrupted request is discarded and produces no response.
- req_ready is high only in IDLE. A request is accepted on a rising edge with req_valid and req_ready both high, and req_* are latched at that edge.
- States: IDLE, WR, RD, SW_WR, RESP.
- IDLE, on accept:
  - WRITE goes to WR.
  - READ or SWAP goes to RD.
  - Reserved op pulses err for one cycle and stays in IDLE.
- WR, one cycle:
  - rin[reg] = 1 and d_out = wdata.
  - Next state IDLE. Writes produce no response.
- RD, one cycle:
  - rout[reg] = 1.
  - ba_out = 1 iff req_base and reg == 0. req_base with a nonzero index is ignored and ba_out stays 0.
  - bus_in is captured into rsp_data at the end of the cycle.
  - READ goes to RESP. SWAP goes to SW_WR.
- SW_WR, one cycle:
  - rin[reg] = 1 and d_out = wdata.
  - Next state RESP. rsp_data holds the old value.
- RESP:
  - rsp_valid = 1, with rsp_data stable until the rsp_valid and rsp_ready handshake.
  - Next state IDLE.
  - No new request is accepted while in RESP.
- rin and rout are never both nonzero in the same cycle, and each has at most one bit set. d_out holds its last value outside WR and SW_WR.
- Latency, counted from the accept edge (cycle 0):
  - WRITE: strobe in cycle 1; req_ready again in cycle 2.
  - READ: rsp_valid in cycle 2 at the earliest.
  - SWAP: rsp_valid in cycle 3 at the earliest.
  - With rsp_ready held high, back-to-back reads take 3 cycles each.
- Width rules: no arithmetic. Index decode is exact; all NREGS = 2^AW values are valid.

Decomposition:
- Package reg_access_pkg:
  - state enum;
  - op constants OP_READ, OP_WRITE, OP_SWAP, OP_RSVD;
  - NREGS, DW, AW defaults.
- Sub-module reg_sel_decoder: AW-to-NREGS one-hot decoder with an enable input, instantiated twice (once for rin, once for rout).

Test Plan:
- Reset mid-operation: assert clear_n low during RD of R5 -> rout = 0 immediately, no rsp_valid after release, req_ready = 1 in the first cycle after release.
- WRITE R3 = 0xDEADBEEF, then READ R3 -> rin = 0x0008 for exactly one cycle with d_out = 0xDEADBEEF; rout = 0x0008 for one cycle; rsp_data = 0xDEADBEEF at rsp_valid.
- R0 = 0x12345678:
  - READ R0 with req_base = 1 -> ba_out = 1, rsp_data = 0x00000000.
  - READ R0 with req_base = 0 -> ba_out = 0, rsp_data = 0x12345678.
  - READ R7 with req_base = 1 -> ba_out = 0.
- SWAP R15 (holding 0x0000000A) with wdata 0x0000000B -> rsp_data = 0x0000000A; a following READ R15 returns 0x0000000B; rout and rin never overlap.
- Hold rsp_ready low for 5 cycles on a READ -> rsp_valid and rsp_data stable and req_ready = 0 throughout; state is IDLE one cycle after the handshake.
- Reserved op 11 -> err pulses for one cycle, no strobes, no response, req_ready stays 1.
